manchester_frame_decoder: RTL and testbench

- Parametrised successor to the single-bit Manchester edge decoder.
- Consumes single-cycle pos_edge/neg_edge strobes from the upstream synchroniser/edge detector.
- Recovers bits with configurable bit period, polarity convention and bit order. Assembles WORD_WIDTH-bit words and reports frame start, end and errors.
- Sits between the edge detector and the frame buffer, replacing the manchester_clock/manchester_data pair with a word-valid stream.

---
 rtl/manchester_pkg.sv | 27 ++
 rtl/manchester_frame_decoder_if.sv | 42 ++++
 rtl/manchester_deserializer.sv | 69 ++++++
 rtl/manchester_frame_decoder.sv | 139 +++++++++++++
 tb/tb_manchester_frame_decoder.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/manchester_pkg.sv
// Shared definitions for the Manchester decoder/encoder family: state encoding,
// polarity conventions and the timing-window helpers derived from the bit period.
package manchester_pkg;

    typedef enum logic [1:0] {
        ARMED = 2'd0,
        TRACK = 2'd1,
        HOLD  = 2'd2
    } dec_state_e;

    localparam int POLARITY_THOMAS = 0;
    localparam int POLARITY_IEEE   = 1;

    // Strobes closer than this to the last accepted edge are bit-boundary transitions.
    function automatic int blank_cycles(input int period);
        return (3 * period) / 4;
    endfunction

    function automatic int window_cycles(input int period);
        return period / 2;
    endfunction

    function automatic int holdoff_cycles(input int period);
        return period / 2;
    endfunction

endpackage

// File: rtl/manchester_frame_decoder_if.sv
// Edge-strobe input and decoded bit/word/frame stream of the Manchester frame decoder.
interface manchester_frame_decoder_if #(
    parameter int WORD_WIDTH = 8
);
    logic                  pos_edge;
    logic                  neg_edge;
    logic                  bit_valid;
    logic                  bit_data;
    logic                  word_valid;
    logic [WORD_WIDTH-1:0] word_data;
    logic                  frame_start;
    logic                  frame_end;
    logic                  frame_error;
    logic                  busy;

    // Upstream side: edge detector drives strobes, frame buffer consumes the stream.
    modport master (
        output pos_edge,
        output neg_edge,
        input  bit_valid,
        input  bit_data,
        input  word_valid,
        input  word_data,
        input  frame_start,
        input  frame_end,
        input  frame_error,
        input  busy
    );

    modport slave (
        input  pos_edge,
        input  neg_edge,
        output bit_valid,
        output bit_data,
        output word_valid,
        output word_data,
        output frame_start,
        output frame_end,
        output frame_error,
        output busy
    );
endinterface

// File: rtl/manchester_deserializer.sv
// Shifts decoded bits into a WORD_WIDTH word, pulses word_valid on completion and
// reports whether a partially assembled word is pending.
module manchester_deserializer
    import manchester_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int MSB_FIRST  = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  shift_en,
    input  logic                  shift_bit,
    output logic                  word_valid,
    output logic [WORD_WIDTH-1:0] word_data,
    output logic                  partial
);
    localparam int CW = $clog2(WORD_WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WORD_WIDTH - 1);

    logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
    logic [WORD_WIDTH-1:0] word_data_q, word_data_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  word_valid_q, word_valid_d;

    always_comb begin
        shreg_d      = shreg_q;
        count_d      = count_q;
        word_data_d  = word_data_q;
        word_valid_d = 1'b0;
        if (clear) begin
            shreg_d = '0;
            count_d = '0;
        end else if (shift_en) begin
            // MSB-first pushes in at the bottom so the first bit ends at the top.
            if (MSB_FIRST != 0) begin
                shreg_d = {shreg_q[WORD_WIDTH-2:0], shift_bit};
            end else begin
                shreg_d = {shift_bit, shreg_q[WORD_WIDTH-1:1]};
            end
            if (count_q == LAST_IDX) begin
                count_d      = '0;
                word_data_d  = shreg_d;
                word_valid_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shreg_q      <= '0;
            count_q      <= '0;
            word_data_q  <= '0;
            word_valid_q <= 1'b0;
        end else begin
            shreg_q      <= shreg_d;
            count_q      <= count_d;
            word_data_q  <= word_data_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign word_valid = word_valid_q;
    assign word_data  = word_data_q;
    assign partial    = (count_q != '0);

endmodule

// File: rtl/manchester_frame_decoder.sv
// Manchester frame decoder: turns edge strobes into bits using a blanking/accept
// window timed from the last accepted edge, and frames them into words.
module manchester_frame_decoder
    import manchester_pkg::*;
#(
    parameter int PERIOD     = 18,
    parameter int WORD_WIDTH = 8,
    parameter int POLARITY   = 0,
    parameter int MSB_FIRST  = 0,
    parameter int TW         = $clog2(2 * PERIOD) + 1
) (
    input  logic                     clock,
    input  logic                     reset,
    manchester_frame_decoder_if.slave bus
);
    localparam logic [TW-1:0] BLANK_T     = TW'(blank_cycles(PERIOD));
    localparam logic [TW-1:0] WIN_END_T   = TW'(blank_cycles(PERIOD) + window_cycles(PERIOD));
    localparam logic [TW-1:0] HOLD_LAST_T = TW'(holdoff_cycles(PERIOD) - 1);

    dec_state_e    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          bit_valid_q, bit_valid_d;
    logic          bit_data_q, bit_data_d;
    logic          frame_start_q, frame_start_d;
    logic          frame_end_q, frame_end_d;
    logic          frame_error_q, frame_error_d;
    logic          busy_q, busy_d;

    logic          sync_edge;
    logic          edge_bit;
    logic          in_window;
    logic          shift_en;
    logic          des_clear;
    logic          partial;

    // The sync edge is the transition that would encode a 0 in the chosen convention.
    assign sync_edge = (POLARITY == POLARITY_THOMAS) ? bus.pos_edge : bus.neg_edge;
    assign edge_bit  = (POLARITY == POLARITY_IEEE) ? bus.pos_edge : bus.neg_edge;
    assign in_window = (timer_q >= BLANK_T) && (timer_q < WIN_END_T);

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        bit_valid_d   = 1'b0;
        bit_data_d    = bit_data_q;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        frame_error_d = 1'b0;
        shift_en      = 1'b0;
        des_clear     = 1'b0;
        case (state_q)
            ARMED: begin
                timer_d = '0;
                if (sync_edge) begin
                    state_d       = TRACK;
                    frame_start_d = 1'b1;
                end
            end
            TRACK: begin
                timer_d = timer_q + TW'(1);
                if (in_window && bus.pos_edge && bus.neg_edge) begin
                    state_d       = HOLD;
                    timer_d       = '0;
                    frame_end_d   = 1'b1;
                    frame_error_d = 1'b1;
                    des_clear     = 1'b1;
                end else if (in_window && (bus.pos_edge || bus.neg_edge)) begin
                    timer_d     = '0;
                    bit_valid_d = 1'b1;
                    bit_data_d  = edge_bit;
                    shift_en    = 1'b1;
                end else if (timer_q >= WIN_END_T) begin
                    // Silence through the whole window: the frame is over.
                    state_d       = HOLD;
                    timer_d       = '0;
                    frame_end_d   = 1'b1;
                    frame_error_d = partial;
                    des_clear     = 1'b1;
                end
            end
            HOLD: begin
                timer_d = timer_q + TW'(1);
                if (timer_q >= HOLD_LAST_T) begin
                    state_d = ARMED;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = ARMED;
                timer_d = '0;
            end
        endcase
        busy_d = (state_d != ARMED);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ARMED;
            timer_q       <= '0;
            bit_valid_q   <= 1'b0;
            bit_data_q    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            bit_valid_q   <= bit_valid_d;
            bit_data_q    <= bit_data_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            frame_error_q <= frame_error_d;
            busy_q        <= busy_d;
        end
    end

    manchester_deserializer #(
        .WORD_WIDTH (WORD_WIDTH),
        .MSB_FIRST  (MSB_FIRST)
    ) u_deser (
        .clock      (clock),
        .reset      (reset),
        .clear      (des_clear),
        .shift_en   (shift_en),
        .shift_bit  (edge_bit),
        .word_valid (bus.word_valid),
        .word_data  (bus.word_data),
        .partial    (partial)
    );

    assign bus.bit_valid   = bit_valid_q;
    assign bus.bit_data    = bit_data_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_end   = frame_end_q;
    assign bus.frame_error = frame_error_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_manchester_frame_decoder.sv
// Bench for manchester_frame_decoder: two configurations, directed and random frames
// scored against a timestamp-level model of the decoding rules.
module tb_manchester_frame_decoder;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic a_pos = 1'b0, a_neg = 1'b0, b_pos = 1'b0, b_neg = 1'b0;
    int   dsel  = 0;
    int   cyc   = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    manchester_frame_decoder_if #(.WORD_WIDTH(8))  ifa ();
    manchester_frame_decoder_if #(.WORD_WIDTH(16)) ifb ();

    assign ifa.pos_edge = a_pos;
    assign ifa.neg_edge = a_neg;
    assign ifb.pos_edge = b_pos;
    assign ifb.neg_edge = b_neg;

    manchester_frame_decoder #(.PERIOD(18), .WORD_WIDTH(8), .POLARITY(0), .MSB_FIRST(0)) dut_a (
        .clock (clock), .reset (reset), .bus (ifa));
    manchester_frame_decoder #(.PERIOD(8), .WORD_WIDTH(16), .POLARITY(1), .MSB_FIRST(1)) dut_b (
        .clock (clock), .reset (reset), .bus (ifb));

    logic        o_bit_valid, o_bit_data, o_word_valid, o_frame_start, o_frame_end, o_frame_error, o_busy;
    logic [31:0] o_word;
    assign o_bit_valid   = (dsel != 0) ? ifb.bit_valid   : ifa.bit_valid;
    assign o_bit_data    = (dsel != 0) ? ifb.bit_data    : ifa.bit_data;
    assign o_word_valid  = (dsel != 0) ? ifb.word_valid  : ifa.word_valid;
    assign o_word        = (dsel != 0) ? 32'(ifb.word_data) : 32'(ifa.word_data);
    assign o_frame_start = (dsel != 0) ? ifb.frame_start : ifa.frame_start;
    assign o_frame_end   = (dsel != 0) ? ifb.frame_end   : ifa.frame_end;
    assign o_frame_error = (dsel != 0) ? ifb.frame_error : ifa.frame_error;
    assign o_busy        = (dsel != 0) ? ifb.busy        : ifa.busy;

    // Observed events, stamped with the cycle in which they were visible.
    logic [63:0] obs_bit[$], obs_word[$], obs_start[$], obs_end[$], obs_rise[$], obs_fall[$];
    logic        prev_busy = 1'b0;

    always @(negedge clock) begin
        if (o_bit_valid)   obs_bit.push_back({32'(cyc), 31'd0, o_bit_data});
        if (o_word_valid)  obs_word.push_back({32'(cyc), o_word});
        if (o_frame_start) obs_start.push_back(64'(cyc));
        if (o_frame_end)   obs_end.push_back({32'(cyc), 31'd0, o_frame_error});
        if (o_busy && !prev_busy) obs_rise.push_back(64'(cyc));
        if (!o_busy && prev_busy) obs_fall.push_back(64'(cyc));
        prev_busy <= o_busy;
    end

    // Stimulus frame: absolute offsets from the sync edge; kind 0=pos, 1=neg, 2=both.
    int ev_off[$];
    int ev_kind[$];
    int cur;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int kind_of(input int v);
        return (v == dsel) ? 0 : 1;
    endfunction

    task automatic new_frame();
        ev_off.delete();
        ev_kind.delete();
        cur = 0;
        ev_off.push_back(0);
        ev_kind.push_back(kind_of(0));
    endtask

    task automatic add_edge(input int gap, input int kind);
        cur += gap;
        ev_off.push_back(cur);
        ev_kind.push_back(kind);
    endtask

    task automatic add_extra(input int off, input int kind);
        ev_off.push_back(cur + off);
        ev_kind.push_back(kind);
    endtask

    task automatic set_strobes(input logic p, input logic n);
        if (dsel != 0) begin b_pos = p; b_neg = n; end
        else begin a_pos = p; a_neg = n; end
    endtask

    task automatic clear_obs();
        obs_bit.delete(); obs_word.delete(); obs_start.delete();
        obs_end.delete(); obs_rise.delete(); obs_fall.delete();
    endtask

    // Starts in the current cycle (entered #1 after a rising edge).
    task automatic drive_events(input int n);
        int idx = 0;
        for (int off = 0; idx < n; off++) begin
            logic p, q;
            p = 1'b0;
            q = 1'b0;
            while (idx < n && ev_off[idx] == off) begin
                if (ev_kind[idx] != 1) p = 1'b1;
                if (ev_kind[idx] != 0) q = 1'b1;
                idx++;
            end
            set_strobes(p, q);
            @(posedge clock); #1;
        end
        set_strobes(1'b0, 1'b0);
    endtask

    task automatic run_frame(input string tag);
        int per, ww, pol, msb, blank, wend, hold;
        int last, nb, n_drive, exp_end, exp_err, t0;
        logic [31:0] acc;
        logic [63:0] eb[$], ew[$];
        per   = (dsel != 0) ? 8 : 18;
        ww    = (dsel != 0) ? 16 : 8;
        pol   = dsel;
        msb   = dsel;
        blank = (3 * per) / 4;
        wend  = blank + per / 2;
        hold  = per / 2;
        last = 0; nb = 0; acc = '0; exp_end = -1; exp_err = 0;
        n_drive = ev_off.size();
        for (int i = 1; i < ev_off.size(); i++) begin
            int d, v;
            d = ev_off[i] - last - 1;
            if (d >= wend) begin n_drive = i; break; end
            if (d >= blank) begin
                if (ev_kind[i] == 2) begin
                    exp_end = ev_off[i] + 1; exp_err = 1; n_drive = i + 1;
                    break;
                end
                v = (ev_kind[i] == 0) ? pol : 1 - pol;
                eb.push_back({32'(ev_off[i] + 1), 32'(v)});
                if (msb != 0) acc = {acc[30:0], v[0]};
                else acc[nb] = v[0];
                nb++;
                if (nb == ww) begin
                    ew.push_back({32'(ev_off[i] + 1), acc});
                    acc = '0; nb = 0;
                end
                last = ev_off[i];
            end
        end
        if (exp_end < 0) begin
            exp_end = last + wend + 2;
            exp_err = (nb != 0) ? 1 : 0;
        end

        @(posedge clock); #1;
        clear_obs();
        t0 = cyc;
        drive_events(n_drive);
        while (cyc < t0 + exp_end + hold + 4) begin
            @(posedge clock); #1;
        end

        chk({tag, ".start_cnt"}, 64'(obs_start.size()), 64'd1);
        chk({tag, ".start_cyc"}, (obs_start.size() > 0) ? obs_start[0] : '1, 64'(t0 + 1));
        chk({tag, ".busy_rise"}, (obs_rise.size() > 0) ? obs_rise[0] : '1, 64'(t0 + 1));
        chk({tag, ".bit_cnt"}, 64'(obs_bit.size()), 64'(eb.size()));
        foreach (eb[i])
            chk($sformatf("%s.bit%0d", tag, i), (i < obs_bit.size()) ? obs_bit[i] : '1,
                {32'(t0 + int'(eb[i][63:32])), eb[i][31:0]});
        chk({tag, ".word_cnt"}, 64'(obs_word.size()), 64'(ew.size()));
        foreach (ew[i])
            chk($sformatf("%s.word%0d", tag, i), (i < obs_word.size()) ? obs_word[i] : '1,
                {32'(t0 + int'(ew[i][63:32])), ew[i][31:0]});
        chk({tag, ".end_cnt"}, 64'(obs_end.size()), 64'd1);
        chk({tag, ".end"}, (obs_end.size() > 0) ? obs_end[0] : '1, {32'(t0 + exp_end), 32'(exp_err)});
        chk({tag, ".busy_fall"}, (obs_fall.size() > 0) ? obs_fall[0] : '1, 64'(t0 + exp_end + hold));
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({o_bit_valid, o_bit_data, o_word_valid, o_frame_start,
                    o_frame_end, o_frame_error, o_busy, o_word});
    endfunction

    initial begin
        logic [7:0]  d8;
        logic [15:0] d16;

        repeat (3) @(posedge clock);
        #1;
        dsel = 0; #1;
        chk("reset_a", all_outputs(), 64'd0);
        dsel = 1; #1;
        chk("reset_b", all_outputs(), 64'd0);
        reset = 1'b0;
        dsel = 0;
        repeat (2) @(posedge clock);
        #1;

        new_frame();
        d8 = 8'hA5;
        for (int b = 0; b < 8; b++) add_edge(18, kind_of(int'(d8[b])));
        run_frame("a5_nominal");

        new_frame();
        for (int b = 0; b < 8; b++) add_edge((b % 2 == 0) ? 14 : 22, kind_of(int'(d8[b])));
        run_frame("a5_jitter");

        new_frame();
        for (int b = 0; b < 8; b++) begin
            add_extra(6, 1);
            add_extra(10, 0);
            add_edge(18, kind_of(0));
        end
        run_frame("zeros_boundary");

        new_frame();
        add_edge(18, kind_of(1));
        add_edge(18, kind_of(0));
        add_edge(12, kind_of(1));
        run_frame("early_edge");

        new_frame();
        for (int b = 0; b < 5; b++) add_edge(18, kind_of(int'($urandom_range(0, 1))));
        run_frame("partial");

        new_frame();
        add_edge(18, kind_of(1));
        add_edge(16, 2);
        run_frame("conflict");

        for (int f = 0; f < 3; f++) begin
            new_frame();
            for (int w = 0; w < 2; w++) begin
                d8 = 8'($urandom_range(0, 255));
                for (int b = 0; b < 8; b++) begin
                    if ($urandom_range(0, 1) == 1) add_extra(int'($urandom_range(1, 12)), int'($urandom_range(0, 2)));
                    add_edge(int'($urandom_range(14, 22)), kind_of(int'(d8[b])));
                end
            end
            run_frame($sformatf("rand_a%0d", f));
        end

        // Reset in the middle of a word, with a sync strobe in the reset cycle.
        new_frame();
        add_edge(18, kind_of(1));
        add_edge(18, kind_of(0));
        add_edge(18, kind_of(1));
        @(posedge clock); #1;
        drive_events(ev_off.size());
        repeat (4) @(posedge clock);
        #1;
        chk("midframe_busy", 64'(o_busy), 64'd1);
        reset = 1'b1;
        set_strobes(1'b1, 1'b0);
        @(posedge clock); #1;
        reset = 1'b0;
        set_strobes(1'b0, 1'b0);
        clear_obs();
        @(negedge clock);
        chk("after_reset", all_outputs(), 64'd0);
        @(posedge clock); #1;
        chk("reset_edge_dropped", 64'(o_busy), 64'd0);
        repeat (40) @(posedge clock);
        #1;
        chk("reset_no_end", 64'(obs_end.size()), 64'd0);
        chk("reset_no_bits", 64'(obs_bit.size()), 64'd0);

        dsel = 1;
        new_frame();
        d16 = 16'h1234;
        for (int b = 15; b >= 0; b--) begin
            if ($urandom_range(0, 1) == 1) add_extra(int'($urandom_range(1, 6)), int'($urandom_range(0, 2)));
            add_edge(int'($urandom_range(7, 10)), kind_of(int'(d16[b])));
        end
        for (int b = 0; b < 3; b++) add_edge(int'($urandom_range(7, 10)), kind_of(int'($urandom_range(0, 1))));
        run_frame("b_1234_plus3");

        for (int f = 0; f < 2; f++) begin
            new_frame();
            d16 = 16'($urandom_range(0, 65535));
            for (int b = 15; b >= 0; b--) add_edge(int'($urandom_range(7, 10)), kind_of(int'(d16[b])));
            run_frame($sformatf("rand_b%0d", f));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
